// File: rtl/div_pkg.sv
// div_pkg: shared divider width and FSM state encoding.
package div_pkg;
  localparam int DIV_W = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/div16_ctrl_if.sv
// div16_ctrl_if: start/done handshake and operand/result bus of the divider.
interface div16_ctrl_if
  import div_pkg::*;
#(parameter int WIDTH = DIV_W);
  logic start;
  logic [WIDTH-1:0] dividend, divisor;
  logic busy, done, div0;
  logic [WIDTH-1:0] quotient, remainder;
  modport master (output start, dividend, divisor, input busy, done, div0, quotient, remainder);
  modport slave (input start, dividend, divisor, output busy, done, div0, quotient, remainder);
endinterface

// File: rtl/div_step.sv
// div_step: WIDTH+1-bit compare-subtract on a ripple subtractor (inverted B, carry-in 1).
module div_step #(parameter int WIDTH = 16) (
  input  logic [WIDTH:0]   s,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] t,
  output logic             borrow
);
  logic [WIDTH:0] nb;
  logic c;
  assign nb = ~{1'b0, divisor};
  // The top difference bit is always 0 when no borrow, so only the carry out is kept.
  always_comb begin
    c = 1'b1;
    t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t[i] = s[i] ^ nb[i] ^ c;
      c = (s[i] & nb[i]) | (c & (s[i] ^ nb[i]));
    end
    borrow = ~((s[WIDTH] & nb[WIDTH]) | (c & (s[WIDTH] ^ nb[WIDTH])));
  end
endmodule

// File: rtl/div16_ctrl.sv
// div16_ctrl: sequential restoring divider, one quotient bit per cycle.
// Define SIGNED_DIV_EN for two's-complement operands (adds a FIX sign-correction state).
module div16_ctrl
  import div_pkg::*;
#(parameter int WIDTH = DIV_W) (
  input logic clk,
  input logic rst_n,
  div16_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] p, q, dvs, t, p_nx, q_nx, a_mag, b_mag;
  logic borrow, accept;
`ifdef SIGNED_DIV_EN
  logic neg_q, neg_r;
  assign a_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign b_mag = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
`else
  assign a_mag = bus.dividend;
  assign b_mag = bus.divisor;
`endif
  assign accept = bus.start && (state == IDLE || state == DONE);
  div_step #(.WIDTH(WIDTH)) u_step (
    .s({p, q[WIDTH-1]}),
    .divisor(dvs),
    .t(t),
    .borrow(borrow)
  );
  assign p_nx = borrow ? {p[WIDTH-2:0], q[WIDTH-1]} : t;
  assign q_nx = {q[WIDTH-2:0], ~borrow};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      p <= '0;
      q <= '0;
      dvs <= '0;
`ifdef SIGNED_DIV_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.div0 <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        p <= '0;
        q <= a_mag;
        dvs <= b_mag;
        cnt <= CW'(WIDTH - 1);
`ifdef SIGNED_DIV_EN
        neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
        neg_r <= bus.dividend[WIDTH-1];
`endif
        if (bus.divisor == '0) begin
          state <= DONE;
          bus.done <= 1'b1;
          bus.div0 <= 1'b1;
          bus.quotient <= '1;
          bus.remainder <= bus.dividend;
        end else begin
          state <= RUN;
          bus.busy <= 1'b1;
        end
      end else if (state == RUN) begin
        p <= p_nx;
        q <= q_nx;
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
`ifdef SIGNED_DIV_EN
          state <= FIX;
`else
          state <= DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          bus.div0 <= 1'b0;
          bus.quotient <= q_nx;
          bus.remainder <= p_nx;
`endif
        end
      end
`ifdef SIGNED_DIV_EN
      else if (state == FIX) begin
        state <= DONE;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        bus.div0 <= 1'b0;
        bus.quotient <= neg_q ? -q : q;
        bus.remainder <= neg_r ? -p : p;
      end
`endif
      else if (state == DONE) state <= IDLE;
    end
endmodule
